alu_result_queue: RTL

Downstream capture stage for the combinational ALU. It accepts operand transactions (op, a, b) over a valid/ready handshake and forwards them straight to the ALU's operand ports. In the same cycle it samples the ALU result and pushes {op, a, b, r, zero} into a DEPTH-entry FIFO. The queue presents the oldest entry to a downstream consumer (checker, scoreboard or writeback) over a second valid/ready handshake. Together with the ALU wrapper it forms the registered boundary between stimulus and consumer.

---
 rtl/alu_result_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_result_queue.sv
// Capture stage for the combinational ALU: forwards operands, queues {op,a,b,r,zero} for a consumer.
// Latency: an accepted entry appears on out_* one cycle after the accepting edge; no empty bypass.
// Backpressure: in_ready drops when the queue holds DEPTH entries; it depends on registered level only.

// Generic clear-on-reset FIFO with an occupancy count.
// Latency: one cycle from push to visible head; no bypass when empty.
// Backpressure: push_rdy is low at full, and a same-cycle pop does not free a slot.
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Full/empty come from the registered level, never from pointer comparison.
  assign push_rdy = (level < LW'(DEPTH));
  assign pop_vld  = (level != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  // Storage, pointers and level; reset wipes every entry so stale data never reaches the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module alu_result_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_WIDTH-1:0]      in_op,
  input  logic [DATA_WIDTH-1:0]    in_a,
  input  logic [DATA_WIDTH-1:0]    in_b,
  output logic [OP_WIDTH-1:0]      alu_op,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  input  logic [DATA_WIDTH-1:0]    alu_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_WIDTH-1:0]      out_op,
  output logic [DATA_WIDTH-1:0]    out_a,
  output logic [DATA_WIDTH-1:0]    out_b,
  output logic [DATA_WIDTH-1:0]    out_r,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              n_done
);
  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] r;
    logic                  zero;
  } entry_t;

  entry_t wr_entry;
  entry_t rd_entry;

  // Operands go to the ALU ungated so its result is settled by the accepting edge.
  assign alu_op = in_op;
  assign alu_a  = in_a;
  assign alu_b  = in_b;

  assign wr_entry = '{op: in_op, a: in_a, b: in_b, r: alu_r, zero: (alu_r == '0)};

  alu_result_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (wr_entry),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (rd_entry),
    .level    (level)
  );

  assign out_op   = rd_entry.op;
  assign out_a    = rd_entry.a;
  assign out_b    = rd_entry.b;
  assign out_r    = rd_entry.r;
  assign out_zero = rd_entry.zero;

  // Completed-entry counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_done <= '0;
    end else if (out_valid && out_ready) begin
      n_done <= n_done + 16'd1;
    end
  end
endmodule
